imem_loader: RTL and testbench
==============================

Name: imem_loader

Overview:
- Upstream of the single-cycle core's instruction memory.
- Receives a program as a byte stream over a valid/ready handshake and assembles little-endian 32-bit instruction words.
- Writes each word into instruction memory through a dedicated write port.
- Holds the core in reset while loading and releases it only once the program is complete.
- Reloadable at run time via start_i.

Parameters:
- INSTRUC_WIDTH, 32, instruction word width in bits; fixed at 4 bytes per word.
- ADDRESS_WIDTH, 32, width of the instruction memory address (byte address, same as the PC).
- MEM_SIZE, 10, instruction memory depth in words.
- CW, $clog2(MEM_SIZE+1), width of the word counter.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start_i  in  1  single-cycle pulse; begins a (re)load.
- byte_valid_i  in  1  byte_data_i is valid this cycle.
- byte_data_i  in  8  program byte.
- byte_last_i  in  1  qualifies the final program byte; sampled with byte_valid_i.
- byte_ready_o  out  1  loader accepts a byte this cycle.
- imem_we_o  out  1  instruction memory write enable.
- imem_addr_o  out  ADDRESS_WIDTH  byte address of the word being written (word_idx*4).
- imem_wdata_o  out  INSTRUC_WIDTH  assembled instruction word.
- core_rst_o  out  1  reset to the core (pc_counter, reg_file, data_memory); active-high.
- busy_o  out  1  load in progress.
- done_o  out  1  program loaded and core running.
- word_count_o  out  CW  number of words written in the last or current load.

Behaviour:
- Handshake: a byte transfers in a cycle where byte_valid_i && byte_ready_o. byte_ready_o depends only on state, never on byte_valid_i.
- States are IDLE, RECV, WRITE and RUN.
- IDLE:
  - Outputs: byte_ready_o=0, core_rst_o=1, busy_o=0, done_o=0.
  - start_i -> RECV; clear byte_idx, word_idx and the assembly register.
- RECV:
  - Outputs: byte_ready_o=1, busy_o=1, core_rst_o=1.
  - Each accepted byte is stored at bits [8*byte_idx+7 : 8*byte_idx] (little-endian); byte_idx increments.
  - 4th byte accepted, or byte_last_i accepted -> WRITE. Unfilled upper bytes are 0 (zero-padded partial word). Latch a last flag if byte_last_i was set.
- WRITE (exactly 1 cycle):
  - Outputs: imem_we_o=1, imem_addr_o=word_idx<<2, imem_wdata_o=assembled word, byte_ready_o=0.
  - Next cycle: word_idx+1 and word_count_o=word_idx+1; byte_idx and the assembly register clear.
  - If the last flag is set or word_idx+1==MEM_SIZE -> RUN, else -> RECV.
- RUN:
  - Outputs: core_rst_o=0, done_o=1, busy_o=0, byte_ready_o=0.
  - start_i -> RECV; core_rst_o re-asserts the following cycle and word_count_o clears.
- start_i is ignored in RECV and WRITE.
- Memory full: after MEM_SIZE words, go to RUN even without byte_last_i. Further bytes are not accepted (byte_ready_o=0).
- Latency: a byte accepted as the 4th byte in cycle n produces the imem write in cycle n+1. core_rst_o falls in the cycle after the final WRITE.
- Throughput: a steady stream loads one word per 5 cycles.
- imem_we_o is high only in WRITE. imem_addr_o and imem_wdata_o hold their last values elsewhere.
- Reset, including mid-load: state=IDLE, all counters and the assembly register 0.
  - Outputs: imem_we_o=0, imem_addr_o=0, imem_wdata_o=0, byte_ready_o=0, core_rst_o=1, busy_o=0, done_o=0, word_count_o=0.
  - A partial word is discarded. Words already written stay in memory.
- rst overrides start_i when both are high.
- Empty program: byte_last_i is always qualified by valid. There is no zero-length load; the minimum is one word.

Test Plan:
- Reset then start_i, stream 13 00 50 00 (byte_last_i on the 4th byte): one write with addr=0, wdata=0x00500013; word_count_o=1; core_rst_o falls 1 cycle after WRITE; done_o=1.
- Stream 3 full words back-to-back with byte_valid_i held high: writes at addr 0, 4 and 8; byte_ready_o low exactly in each WRITE cycle; 15 cycles total from the first byte to the last write.
- Stream 6 bytes AA BB CC DD 11 22 with last on 22: second write addr=4, wdata=0x00002211; word_count_o=2.
- Stream 44 bytes without byte_last_i and MEM_SIZE=10: 10 writes (last addr=36), then RUN; the remaining 4 bytes see byte_ready_o=0.
- Assert rst after 2 bytes of word 1: no write occurs; all outputs return to reset values. A new start_i reloads from addr 0.
- In RUN, pulse start_i: core_rst_o=1 next cycle; the reload overwrites addr 0; done_o=0 until the new load completes.

Source files
------------

// File: rtl/imem_loader.sv
// Byte-stream program loader for the single-cycle core's instruction memory.
// Packs little-endian bytes into words, writes them out and holds the core in reset until loaded.
module imem_loader #(
    parameter int INSTRUC_WIDTH = 32,
    parameter int ADDRESS_WIDTH = 32,
    parameter int MEM_SIZE      = 10,
    parameter int CW            = $clog2(MEM_SIZE + 1)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start_i,
    input  logic                     byte_valid_i,
    input  logic [7:0]               byte_data_i,
    input  logic                     byte_last_i,
    output logic                     byte_ready_o,
    output logic                     imem_we_o,
    output logic [ADDRESS_WIDTH-1:0] imem_addr_o,
    output logic [INSTRUC_WIDTH-1:0] imem_wdata_o,
    output logic                     core_rst_o,
    output logic                     busy_o,
    output logic                     done_o,
    output logic [CW-1:0]            word_count_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RECV  = 2'd1,
        WRITE = 2'd2,
        RUN   = 2'd3
    } state_t;

    state_t                   state;
    state_t                   state_next;

    logic [1:0]               byte_idx;
    logic [CW-1:0]            word_idx;
    logic [CW-1:0]            word_count;
    logic [INSTRUC_WIDTH-1:0] asm_word;
    logic [INSTRUC_WIDTH-1:0] merged;
    logic [INSTRUC_WIDTH-1:0] wdata_q;
    logic [ADDRESS_WIDTH-1:0] addr_q;
    logic                     last_flag;

    logic                     accept;
    logic                     word_end;
    logic                     mem_full;

    assign accept   = (state == RECV) && byte_valid_i;
    assign word_end = accept && ((byte_idx == 2'd3) || byte_last_i);
    // True while writing the word that occupies the final memory slot.
    assign mem_full = (word_idx == CW'(MEM_SIZE - 1));

    // Drop the incoming byte into its little-endian lane of the word being assembled.
    always_comb begin
        merged = asm_word;
        case (byte_idx)
            2'd0:    merged[7:0]   = byte_data_i;
            2'd1:    merged[15:8]  = byte_data_i;
            2'd2:    merged[23:16] = byte_data_i;
            default: merged[31:24] = byte_data_i;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next   = state;
        byte_ready_o = 1'b0;
        imem_we_o    = 1'b0;
        core_rst_o   = 1'b1;
        busy_o       = 1'b0;
        done_o       = 1'b0;
        case (state)
            IDLE: begin
                if (start_i) begin
                    state_next = RECV;
                end
            end
            RECV: begin
                byte_ready_o = 1'b1;
                busy_o       = 1'b1;
                if (word_end) begin
                    state_next = WRITE;
                end
            end
            WRITE: begin
                imem_we_o = 1'b1;
                busy_o    = 1'b1;
                if (last_flag || mem_full) begin
                    state_next = RUN;
                end else begin
                    state_next = RECV;
                end
            end
            default: begin
                core_rst_o = 1'b0;
                done_o     = 1'b1;
                if (start_i) begin
                    state_next = RECV;
                end
            end
        endcase
    end

    // Address and data are captured with the final byte so they are stable
    // throughout WRITE and keep their value until the next word completes.
    always_ff @(posedge clk) begin
        if (rst) begin
            byte_idx   <= '0;
            word_idx   <= '0;
            word_count <= '0;
            asm_word   <= '0;
            wdata_q    <= '0;
            addr_q     <= '0;
            last_flag  <= 1'b0;
        end else begin
            case (state)
                IDLE, RUN: begin
                    if (start_i) begin
                        byte_idx   <= '0;
                        word_idx   <= '0;
                        word_count <= '0;
                        asm_word   <= '0;
                        last_flag  <= 1'b0;
                    end
                end
                RECV: begin
                    if (accept) begin
                        asm_word <= merged;
                        byte_idx <= byte_idx + 2'd1;
                        if (word_end) begin
                            addr_q    <= ADDRESS_WIDTH'(word_idx) << 2;
                            wdata_q   <= merged;
                            last_flag <= byte_last_i;
                        end
                    end
                end
                default: begin
                    word_idx   <= word_idx + 1'b1;
                    word_count <= word_idx + 1'b1;
                    byte_idx   <= '0;
                    asm_word   <= '0;
                end
            endcase
        end
    end

    assign imem_addr_o  = addr_q;
    assign imem_wdata_o = wdata_q;
    assign word_count_o = word_count;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: a per-cycle vector table plus streamed multi-word loads.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_i;
    logic        byte_valid_i;
    logic [7:0]  byte_data_i;
    logic        byte_last_i;
    logic        byte_ready_o;
    logic        imem_we_o;
    logic [31:0] imem_addr_o;
    logic [31:0] imem_wdata_o;
    logic        core_rst_o;
    logic        busy_o;
    logic        done_o;
    logic [3:0]  word_count_o;

    int total = 0;
    int bad   = 0;

    imem_loader #(
        .INSTRUC_WIDTH(32),
        .ADDRESS_WIDTH(32),
        .MEM_SIZE     (10)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start_i      (start_i),
        .byte_valid_i (byte_valid_i),
        .byte_data_i  (byte_data_i),
        .byte_last_i  (byte_last_i),
        .byte_ready_o (byte_ready_o),
        .imem_we_o    (imem_we_o),
        .imem_addr_o  (imem_addr_o),
        .imem_wdata_o (imem_wdata_o),
        .core_rst_o   (core_rst_o),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .word_count_o (word_count_o)
    );

    always #5 clk = ~clk;

    localparam logic [1:0] S_I = 2'd0, S_R = 2'd1, S_W = 2'd2, S_U = 2'd3;

    typedef struct packed {
        logic        rst;
        logic        start;
        logic        valid;
        logic [7:0]  data;
        logic        last;
        logic [1:0]  st;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  cnt;
    } vec_t;

    vec_t tbl[$];

    logic [31:0] wa[$];
    logic [31:0] wd[$];
    int          wc[$];
    int          accepted;
    int          first_c;
    int          viol;

    function automatic vec_t mk(input logic r, input logic s, input logic va, input logic [7:0] d,
                                input logic l, input logic [1:0] st, input logic [31:0] a,
                                input logic [31:0] w, input logic [3:0] n);
        vec_t v;
        v.rst = r; v.start = s; v.valid = va; v.data = d; v.last = l;
        v.st = st; v.addr = a; v.wdata = w; v.cnt = n;
        return v;
    endfunction

    // Expected outputs for a row: control flags follow from the state the row names.
    function automatic logic [72:0] exp_of(input vec_t v);
        logic rdy, we, crst, bsy, dn;
        rdy  = (v.st == S_R);
        we   = (v.st == S_W);
        crst = (v.st != S_U);
        bsy  = (v.st == S_R) || (v.st == S_W);
        dn   = (v.st == S_U);
        return {rdy, we, v.addr, v.wdata, crst, bsy, dn, v.cnt};
    endfunction

    function automatic logic [72:0] act_outs();
        return {byte_ready_o, imem_we_o, imem_addr_o, imem_wdata_o,
                core_rst_o, busy_o, done_o, word_count_o};
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start_i = 1'b1;
    endtask

    // Offers bytes (value idx+1) for ncyc cycles, recording every memory write.
    task automatic stream(input int n, input bit with_last, input int ncyc);
        int idx;
        idx = 0;
        first_c = -1;
        viol = 0;
        wa.delete(); wd.delete(); wc.delete();
        for (int c = 0; c < ncyc; c++) begin
            @(negedge clk);
            start_i = 1'b0;
            if (imem_we_o) begin
                wa.push_back(imem_addr_o);
                wd.push_back(imem_wdata_o);
                wc.push_back(c);
                if (byte_ready_o) viol++;
            end else if (busy_o && !byte_ready_o) begin
                viol++;
            end
            if (idx < n) begin
                byte_valid_i = 1'b1;
                byte_data_i  = 8'(idx + 1);
                byte_last_i  = with_last && (idx == n - 1);
                if (byte_ready_o) begin
                    if (first_c < 0) first_c = c;
                    idx++;
                end
            end else begin
                byte_valid_i = 1'b0;
                byte_last_i  = 1'b0;
            end
        end
        accepted = idx;
        byte_valid_i = 1'b0;
        byte_last_i  = 1'b0;
    endtask

    task automatic check_writes(input string tag, input int n, input int exp_words);
        logic [31:0] w;
        check($sformatf("%s_nwrites", tag), 128'(wa.size()), 128'(exp_words));
        for (int k = 0; k < wa.size() && k < exp_words; k++) begin
            w = '0;
            for (int j = 0; j < 4; j++) begin
                if (4 * k + j < n) w[8*j +: 8] = 8'(4 * k + j + 1);
            end
            check($sformatf("%s_addr%0d", tag, k), 128'(wa[k]), 128'(4 * k));
            check($sformatf("%s_data%0d", tag, k), 128'(wd[k]), 128'(w));
        end
    endtask

    initial begin
        int we_seen;
        rst = 1'b1; start_i = 1'b0; byte_valid_i = 1'b0; byte_data_i = 8'h00; byte_last_i = 1'b0;

        // load 13 00 50 00, reload from RUN with a 6-byte program, rst over start, IDLE ignores bytes
        tbl.push_back(mk(0,1,0,8'h00,0, S_I, 32'd0, 32'h0,        4'd0));
        tbl.push_back(mk(0,0,1,8'h13,0, S_R, 32'd0, 32'h0,        4'd0));
        tbl.push_back(mk(0,0,1,8'h00,0, S_R, 32'd0, 32'h0,        4'd0));
        tbl.push_back(mk(0,0,1,8'h50,0, S_R, 32'd0, 32'h0,        4'd0));
        tbl.push_back(mk(0,0,1,8'h00,1, S_R, 32'd0, 32'h0,        4'd0));
        tbl.push_back(mk(0,0,0,8'h00,0, S_W, 32'd0, 32'h00500013, 4'd0));
        tbl.push_back(mk(0,0,0,8'h00,0, S_U, 32'd0, 32'h00500013, 4'd1));
        tbl.push_back(mk(0,0,0,8'h00,0, S_U, 32'd0, 32'h00500013, 4'd1));
        tbl.push_back(mk(0,1,0,8'h00,0, S_U, 32'd0, 32'h00500013, 4'd1));
        tbl.push_back(mk(0,0,1,8'hAA,0, S_R, 32'd0, 32'h00500013, 4'd0));
        tbl.push_back(mk(0,1,1,8'hBB,0, S_R, 32'd0, 32'h00500013, 4'd0));
        tbl.push_back(mk(0,0,1,8'hCC,0, S_R, 32'd0, 32'h00500013, 4'd0));
        tbl.push_back(mk(0,0,1,8'hDD,0, S_R, 32'd0, 32'h00500013, 4'd0));
        tbl.push_back(mk(0,0,1,8'h99,1, S_W, 32'd0, 32'hDDCCBBAA, 4'd0));
        tbl.push_back(mk(0,0,1,8'h11,0, S_R, 32'd0, 32'hDDCCBBAA, 4'd1));
        tbl.push_back(mk(0,0,1,8'h22,1, S_R, 32'd0, 32'hDDCCBBAA, 4'd1));
        tbl.push_back(mk(0,1,0,8'h00,0, S_W, 32'd4, 32'h00002211, 4'd1));
        tbl.push_back(mk(0,0,1,8'h55,0, S_U, 32'd4, 32'h00002211, 4'd2));
        tbl.push_back(mk(0,0,0,8'h00,0, S_U, 32'd4, 32'h00002211, 4'd2));
        tbl.push_back(mk(1,1,0,8'h00,0, S_U, 32'd4, 32'h00002211, 4'd2));
        tbl.push_back(mk(0,0,0,8'h00,0, S_I, 32'd0, 32'h0,        4'd0));
        tbl.push_back(mk(0,0,1,8'h77,1, S_I, 32'd0, 32'h0,        4'd0));
        tbl.push_back(mk(0,0,0,8'h00,0, S_I, 32'd0, 32'h0,        4'd0));

        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("reset_state", 128'(act_outs()), 128'(exp_of(mk(0,0,0,8'h0,0,S_I,32'd0,32'h0,4'd0))));

        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            check($sformatf("vec%0d", i), 128'(act_outs()), 128'(exp_of(tbl[i])));
            rst          = tbl[i].rst;
            start_i      = tbl[i].start;
            byte_valid_i = tbl[i].valid;
            byte_data_i  = tbl[i].data;
            byte_last_i  = tbl[i].last;
        end

        // Back-to-back stream: 3 full words plus a 1-byte tail word.
        pulse_start();
        stream(13, 1'b1, 25);
        check_writes("b2b", 13, 4);
        check("b2b_accepted", 128'(accepted), 128'(13));
        check("b2b_ready_vs_we", 128'(viol), 128'(0));
        if (wc.size() >= 3) check("b2b_cycles", 128'(wc[2] - first_c + 1), 128'(15));
        check("b2b_final", 128'({done_o, core_rst_o, word_count_o}), 128'({1'b1, 1'b0, 4'd4}));

        // Memory full: 44 bytes without last; only 40 fit.
        pulse_start();
        stream(44, 1'b0, 60);
        check_writes("full", 40, 10);
        check("full_accepted", 128'(accepted), 128'(40));
        check("full_ready_vs_we", 128'(viol), 128'(0));
        check("full_final", 128'({done_o, core_rst_o, byte_ready_o, word_count_o}),
              128'({1'b1, 1'b0, 1'b0, 4'd10}));

        // Reset two bytes into a word: nothing written, outputs back to reset values.
        pulse_start();
        we_seen = 0;
        @(negedge clk);
        start_i = 1'b0; byte_valid_i = 1'b1; byte_data_i = 8'hA1;
        if (imem_we_o) we_seen++;
        @(negedge clk);
        byte_data_i = 8'hA2;
        if (imem_we_o) we_seen++;
        @(negedge clk);
        rst = 1'b1; byte_data_i = 8'hA3;
        if (imem_we_o) we_seen++;
        @(negedge clk);
        rst = 1'b0; byte_valid_i = 1'b0;
        if (imem_we_o) we_seen++;
        check("midrst_no_write", 128'(we_seen), 128'(0));
        check("midrst_outputs", 128'(act_outs()), 128'(exp_of(mk(0,0,0,8'h0,0,S_I,32'd0,32'h0,4'd0))));

        pulse_start();
        stream(4, 1'b1, 10);
        check_writes("reload", 4, 1);
        check("reload_final", 128'({done_o, core_rst_o, word_count_o}), 128'({1'b1, 1'b0, 4'd1}));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
